// File: rtl/priority_encoder.sv
// Registered 8-to-3 priority encoder with request latching and valid/ready offer.
// Define PRIO_ENC_ROTATE_EN for round-robin priority (PRIO_HIGH is then ignored).
module priority_encoder #(
    parameter logic PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    output logic [2:0] out,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] pending,
    output logic       merged
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t     state_q;
    logic [7:0] pending_q;
    logic [2:0] out_q;
    logic       valid_q;
    logic       merged_q;

    logic       acc;
    logic [7:0] clr;
    logic [7:0] pend_d;
    logic       merged_d;
    logic [2:0] enc_d;

`ifdef PRIO_ENC_ROTATE_EN
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;

    // Ascending search from the pointer; the lowest offset found wins.
    function automatic logic [2:0] enc(input logic [7:0] v, input logic [2:0] ptr);
        logic [2:0] e;
        logic [2:0] idx;
        e = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (v[idx]) e = idx;
        end
        return e;
    endfunction
`else
    function automatic logic [2:0] enc(input logic [7:0] v);
        logic [2:0] e;
        e = 3'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) e = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) e = 3'(i);
        end
        return e;
    endfunction
`endif

    always_comb begin
        acc      = valid_q & ready;
        clr      = acc ? (8'b1 << out_q) : 8'h00;
        pend_d   = (pending_q & ~clr) | in;
        merged_d = |(in & pending_q & ~clr);
`ifdef PRIO_ENC_ROTATE_EN
        ptr_d    = acc ? (out_q + 3'd1) : ptr_q;
        enc_d    = enc(pend_d, ptr_d);
`else
        enc_d    = enc(pend_d);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            out_q     <= 3'd0;
            valid_q   <= 1'b0;
            merged_q  <= 1'b0;
`ifdef PRIO_ENC_ROTATE_EN
            ptr_q     <= 3'd0;
`endif
        end else begin
            pending_q <= pend_d;
            merged_q  <= merged_d;
`ifdef PRIO_ENC_ROTATE_EN
            ptr_q     <= ptr_d;
`endif
            unique case (state_q)
                IDLE: begin
                    if (|pend_d) begin
                        out_q   <= enc_d;
                        valid_q <= 1'b1;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is held stable until accepted; no preemption.
                    if (acc) begin
                        if (|pend_d) begin
                            out_q <= enc_d;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign merged  = merged_q;

endmodule

// File: tb/tb_priority_encoder.sv
// Directed, table-driven bench for priority_encoder (fixed or rotate build).
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] in;
    logic [2:0] out;
    logic       valid;
    logic       ready;
    logic [7:0] pending;
    logic       merged;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] in;
        logic       rdy;
        logic [2:0] out;
        logic       v;
        logic [7:0] p;
        logic       m;
    } vec_t;

    vec_t vecs[23];

    priority_encoder #(.PRIO_HIGH(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .valid  (valid),
        .ready  (ready),
        .pending(pending),
        .merged (merged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] o, input logic v,
                           input logic [7:0] p, input logic m);
        chk({tag, ".out"}, {5'd0, out}, {5'd0, o});
        chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
        chk({tag, ".pending"}, pending, p);
        chk({tag, ".merged"}, {7'd0, merged}, {7'd0, m});
    endtask

    task automatic step(input logic [7:0] i, input logic r);
        in    = i;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        in    = 8'h00;
        ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] i, input logic r, input logic [2:0] o,
                                input logic v, input logic [7:0] p, input logic m);
        vec_t t;
        t.in = i; t.rdy = r; t.out = o; t.v = v; t.p = p; t.m = m;
        return t;
    endfunction

    initial begin
        logic [2:0] exp_rst_out;

        // three-grant burst 7,2,0
        vecs[0]  = mk(8'h85, 1, 3'd7, 1, 8'h85, 0);
        vecs[1]  = mk(8'h00, 1, 3'd2, 1, 8'h05, 0);
        vecs[2]  = mk(8'h00, 1, 3'd0, 1, 8'h01, 0);
        vecs[3]  = mk(8'h00, 1, 3'd0, 0, 8'h00, 0);
        // stall, higher request must not preempt
        vecs[4]  = mk(8'h01, 0, 3'd0, 1, 8'h01, 0);
        vecs[5]  = mk(8'h00, 0, 3'd0, 1, 8'h01, 0);
        vecs[6]  = mk(8'h80, 0, 3'd0, 1, 8'h81, 0);
        vecs[7]  = mk(8'h00, 0, 3'd0, 1, 8'h81, 0);
        vecs[8]  = mk(8'h00, 1, 3'd7, 1, 8'h80, 0);
        vecs[9]  = mk(8'h00, 1, 3'd7, 0, 8'h00, 0);
        // merge then re-arm on the accepting edge
        vecs[10] = mk(8'h08, 0, 3'd3, 1, 8'h08, 0);
        vecs[11] = mk(8'h08, 0, 3'd3, 1, 8'h08, 1);
        vecs[12] = mk(8'h00, 0, 3'd3, 1, 8'h08, 0);
        vecs[13] = mk(8'h08, 1, 3'd3, 1, 8'h08, 0);
        vecs[14] = mk(8'h00, 1, 3'd3, 0, 8'h00, 0);
        // arrivals during back-to-back grants
        vecs[15] = mk(8'h42, 1, 3'd6, 1, 8'h42, 0);
        vecs[16] = mk(8'h00, 1, 3'd1, 1, 8'h02, 0);
        vecs[17] = mk(8'h10, 1, 3'd4, 1, 8'h10, 0);
        vecs[18] = mk(8'h00, 1, 3'd4, 0, 8'h00, 0);
        // ready while idle is ignored
        vecs[19] = mk(8'h00, 1, 3'd4, 0, 8'h00, 0);
        vecs[20] = mk(8'h01, 1, 3'd0, 1, 8'h01, 0);
        vecs[21] = mk(8'h01, 0, 3'd0, 1, 8'h01, 1);
        vecs[22] = mk(8'h00, 1, 3'd0, 0, 8'h00, 0);

        do_reset();
        chk_all("reset", 3'd0, 1'b0, 8'h00, 1'b0);

        for (int c = 0; c < 10; c++) begin
            step(8'h00, 1'b0);
            chk_all($sformatf("idle%0d", c), 3'd0, 1'b0, 8'h00, 1'b0);
        end

`ifdef PRIO_ENC_ROTATE_EN
        exp_rst_out = 3'd0;
        for (int c = 0; c < 9; c++) begin
            step(8'hFF, 1'b1);
            chk($sformatf("rr%0d.out", c), {5'd0, out}, 8'(c % 8));
            chk($sformatf("rr%0d.valid", c), {7'd0, valid}, 8'd1);
            chk($sformatf("rr%0d.pending", c), pending, 8'hFF);
        end
        do_reset();
`else
        exp_rst_out = 3'd3;
        for (int k = 0; k < 23; k++) begin
            step(vecs[k].in, vecs[k].rdy);
            chk_all($sformatf("vec%0d", k), vecs[k].out, vecs[k].v, vecs[k].p, vecs[k].m);
        end
`endif

        // asynchronous reset while offering
        step(8'h0F, 1'b0);
        chk_all("pre_rst", exp_rst_out, 1'b1, 8'h0F, 1'b0);
        in    = 8'h00;
        ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        chk_all("rst_hold", 3'd0, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step(8'h20, 1'b0);
        chk_all("post_rst", 3'd5, 1'b1, 8'h20, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
